// File: rtl/nfa_pkg.sv
// Shared definitions for the NFA engine: memory geometry, the memory word type
// and the memory-loader state encoding.
package nfa_pkg;

    localparam int IN_W      = 64;
    localparam int MEM_W     = 201;
    localparam int BEATS     = (MEM_W + IN_W - 1) / IN_W;
    localparam int MAX_WORDS = 1024;

    typedef logic [MEM_W-1:0] mem_word_t;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2,
        LDR_ERR  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/nfa_mem_loader.sv
// Packs a 64-bit host stream into engine memory words and strobes each completed
// word onto the engine's memory-load port. Flags truncated images and overflow.
module nfa_mem_loader #(
    parameter int IN_W      = nfa_pkg::IN_W,
    parameter int MEM_W     = nfa_pkg::MEM_W,
    parameter int BEATS     = nfa_pkg::BEATS,
    parameter int MAX_WORDS = nfa_pkg::MAX_WORDS
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [IN_W-1:0]                    s_data_i,
    input  logic                               s_valid_i,
    input  logic                               s_last_i,
    output logic                               s_ready_o,
    output logic [MEM_W-1:0]                   mem_o,
    output logic                               mem_en_o,
    output logic [$clog2(MAX_WORDS+1)-1:0]     words_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);
    import nfa_pkg::*;

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_W = BEATS * IN_W;
    localparam int ASM_N = (BEATS > 1) ? BEATS - 1 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    ldr_state_t         r_state;
    ldr_state_t         w_state_next;
    logic [IDX_W-1:0]   r_beat_idx;
    logic [IN_W-1:0]    r_asm [ASM_N];
    logic [ASM_W-1:0]   w_word;
    logic [MEM_W-1:0]   r_mem;
    logic               r_mem_en;
    logic [CNT_W-1:0]   r_words;
    logic               w_load;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_full;
    logic               w_start;

    assign w_load      = (r_state == LDR_LOAD);
    assign w_accept    = w_load && s_valid_i;
    assign w_last_beat = (r_beat_idx == LAST_IDX);
    assign w_full      = (r_words == MAX_CNT);
    assign w_start     = start_i && !w_load;

    // The final beat bypasses the assembly register so the word can be
    // registered on the same edge that accepts it.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            if (gi == BEATS - 1) begin : g_tail
                assign w_word[gi*IN_W +: IN_W] = s_data_i;
            end else begin : g_held
                assign w_word[gi*IN_W +: IN_W] = r_asm[gi];
            end
        end
        if (ASM_W > MEM_W) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^w_word[ASM_W-1:MEM_W];
        end
        if (BEATS == 1) begin : g_no_asm
            logic w_unused_asm;
            assign w_unused_asm = ^r_asm[0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= LDR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (start_i) begin
                    w_state_next = LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                if (w_accept) begin
                    if (w_last_beat) begin
                        // Overflow wins over a clean end-of-image on the same word.
                        if (w_full) begin
                            w_state_next = LDR_ERR;
                        end else if (s_last_i) begin
                            w_state_next = LDR_DONE;
                        end
                    end else if (s_last_i) begin
                        w_state_next = LDR_ERR;
                    end
                end
            end
            default: w_state_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_beat_idx <= '0;
            r_mem      <= '0;
            r_mem_en   <= 1'b0;
            r_words    <= '0;
            for (int i = 0; i < ASM_N; i++) begin
                r_asm[i] <= '0;
            end
        end else begin
            r_mem_en <= 1'b0;
            if (w_start) begin
                r_beat_idx <= '0;
                r_words    <= '0;
                for (int i = 0; i < ASM_N; i++) begin
                    r_asm[i] <= '0;
                end
            end else if (w_accept) begin
                if (w_last_beat) begin
                    r_beat_idx <= '0;
                    if (!w_full) begin
                        r_mem    <= w_word[MEM_W-1:0];
                        r_mem_en <= 1'b1;
                        r_words  <= r_words + 1'b1;
                    end
                end else begin
                    r_asm[r_beat_idx] <= s_data_i;
                    r_beat_idx        <= r_beat_idx + 1'b1;
                end
            end
        end
    end

    assign s_ready_o = w_load;
    assign busy_o    = w_load;
    assign done_o    = (r_state == LDR_DONE);
    assign err_o     = (r_state == LDR_ERR);
    assign mem_o     = r_mem;
    assign mem_en_o  = r_mem_en;
    assign words_o   = r_words;

endmodule

// File: tb/tb_nfa_mem_loader.sv
// Self-checking bench for nfa_mem_loader: randomized streams compared against a
// word-level model of the packing, termination and overflow rules.
module tb_nfa_mem_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [63:0]  s_data;
    logic         s_valid;
    logic         s_last;

    logic         rdy_a, en_a, busy_a, done_a, err_a;
    logic [200:0] mem_a;
    logic [10:0]  words_a;
    logic         rdy_b, en_b, busy_b, done_b, err_b;
    logic [200:0] mem_b;
    logic [1:0]   words_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nfa_mem_loader dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(rdy_a),
        .mem_o(mem_a), .mem_en_o(en_a), .words_o(words_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    nfa_mem_loader #(.MAX_WORDS(2)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(rdy_b),
        .mem_o(mem_b), .mem_en_o(en_b), .words_o(words_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    typedef struct {
        int           c;
        logic [200:0] d;
    } strobe_t;

    strobe_t      qa[$];
    strobe_t      qb[$];
    logic [63:0]  stim_q[$];
    logic [200:0] exp_q[$];
    int           last_idx;
    int           exp_cnt;
    int           exp_n;
    bit           exp_err;
    bit           exp_done;
    bit           use_b = 1'b0;

    always @(negedge clk) begin
        if (en_a) qa.push_back('{c: cyc, d: mem_a});
        if (en_b) qb.push_back('{c: cyc, d: mem_b});
    end

    // Reference: words are 4 consecutive beats, LSB-first, truncated to 201 bits.
    task automatic build_expected(input int maxw);
        logic [255:0] acc;
        acc = '0;
        exp_q.delete();
        exp_cnt  = 0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        exp_n    = stim_q.size();
        for (int i = 0; i < stim_q.size(); i++) begin
            acc[(i % 4) * 64 +: 64] = stim_q[i];
            if (i % 4 == 3) begin
                if (exp_cnt == maxw) begin
                    exp_err = 1'b1; exp_n = i + 1; break;
                end
                exp_q.push_back(acc[200:0]);
                exp_cnt++;
                if (i == last_idx) begin
                    exp_done = 1'b1; exp_n = i + 1; break;
                end
            end else if (i == last_idx) begin
                exp_err = 1'b1; exp_n = i + 1; break;
            end
        end
    endtask

    task automatic fill_random(input int n, input int last);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back({$urandom(), $urandom()});
        last_idx = last;
    endtask

    task automatic fill_basic();
        logic [63:0] base;
        base = 64'h1111_0000_0000_0000;
        stim_q.delete();
        for (int k = 1; k <= 8; k++) stim_q.push_back(base * 64'(k) + 64'((k - 1) / 4));
        last_idx = 7;
    endtask

    task automatic do_start();
        qa.delete();
        qb.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last, input int gap, output bit ok);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (use_b ? rdy_b : rdy_a) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drive(input int maxgap, input int start_at);
        bit ok;
        for (int i = 0; i < exp_n; i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_beat(stim_q[i], i == last_idx, $urandom_range(maxgap, 0), ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL beat_accept: beat %0d not accepted within 16 cycles (required accepted)", i);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy_a, en_a, busy_a, done_a, err_a} !== 5'b0 || mem_a !== '0 || words_a !== '0) begin
            errors++;
            $display("FAIL reset_a: rdy/en/busy/done/err=%b mem=%h words=%0d, required all 0",
                     {rdy_a, en_a, busy_a, done_a, err_a}, mem_a, words_a);
        end
        checks++;
        if ({rdy_b, en_b, busy_b, done_b, err_b} !== 5'b0 || mem_b !== '0 || words_b !== '0) begin
            errors++;
            $display("FAIL reset_b: rdy/en/busy/done/err=%b mem=%h words=%0d, required all 0",
                     {rdy_b, en_b, busy_b, done_b, err_b}, mem_b, words_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b ready=%b, required 0 0 without start", busy_a, rdy_a);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        fill_basic();
        build_expected(1024);
        do_start();
        checks++;
        if (busy_a !== 1'b1 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: busy=%b ready=%b, required 1 1", busy_a, rdy_a);
        end
        drive(0, -1);
        checks++;
        if (done_a !== 1'b1 || en_a !== 1'b1 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_with_strobe: done=%b en=%b ready=%b, required 1 1 0", done_a, en_a, rdy_a);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 2) begin
            errors++;
            $display("FAIL basic_count: strobes=%0d, required 2", qa.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= qa.size() || qa[i].d !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h, required %h", i,
                         (i < qa.size()) ? qa[i].d : 'x, exp_q[i]);
            end
        end
        checks++;
        if (qa.size() == 2 && qa[1].c - qa[0].c != 4) begin
            errors++;
            $display("FAIL basic_spacing: strobes %0d cycles apart, required 4", qa[1].c - qa[0].c);
        end
        checks++;
        if (words_a !== 11'd2 || done_a !== 1'b1 || err_a !== 1'b0 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: words=%0d done=%b err=%b en=%b, required 2 1 0 0",
                     words_a, done_a, err_a, en_a);
        end
        checks++;
        if (mem_a !== exp_q[1]) begin
            errors++;
            $display("FAIL mem_hold: mem=%h, required %h", mem_a, exp_q[1]);
        end
        $display("basic: strobes=%0d words=%0d done=%b", qa.size(), words_a, done_a);
    endtask

    task automatic test_gaps();
        fill_basic();
        build_expected(1024);
        do_start();
        drive(3, 5);
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count: strobes=%0d, required %0d", qa.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= qa.size() || qa[i].d !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_word%0d: got %h, required %h", i,
                         (i < qa.size()) ? qa[i].d : 'x, exp_q[i]);
            end
        end
        checks++;
        if (words_a !== 11'd2 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL gaps_status: words=%0d done=%b, required 2 1", words_a, done_a);
        end
        $display("gaps: strobes=%0d words=%0d", qa.size(), words_a);
    endtask

    task automatic test_early_last();
        fill_random(8, 2);
        build_expected(1024);
        do_start();
        drive(1, -1);
        checks++;
        if (err_a !== 1'b1 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL early_err_timing: err=%b en=%b, required 1 0", err_a, en_a);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 0 || words_a !== '0 || rdy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL early_status: strobes=%0d words=%0d ready=%b done=%b, required 0 0 0 0",
                     qa.size(), words_a, rdy_a, done_a);
        end
        $display("early_last: err=%b words=%0d", err_a, words_a);
    endtask

    task automatic test_overflow();
        use_b = 1'b1;
        fill_random(12, 11);
        build_expected(2);
        do_start();
        drive(2, -1);
        checks++;
        if (err_b !== 1'b1 || en_b !== 1'b0) begin
            errors++;
            $display("FAIL ovf_err_timing: err=%b en=%b, required 1 0", err_b, en_b);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (qb.size() != 2 || words_b !== 2'd2) begin
            errors++;
            $display("FAIL ovf_status: strobes=%0d words=%0d, required 2 2", qb.size(), words_b);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= qb.size() || qb[i].d !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h, required %h", i,
                         (i < qb.size()) ? qb[i].d : 'x, exp_q[i]);
            end
        end
        checks++;
        if (done_a !== 1'b1 || words_a !== 11'd3) begin
            errors++;
            $display("FAIL ovf_large: done=%b words=%0d, required 1 3", done_a, words_a);
        end
        use_b = 1'b0;
        $display("overflow: strobes=%0d err=%b words=%0d", qb.size(), err_b, words_b);
    endtask

    task automatic test_truncation();
        logic [63:0] b3;
        fill_random(4, 3);
        b3 = {55'h7F_FFFF_FFFF_FFFF, 9'($urandom())};
        stim_q[3] = b3;
        build_expected(1024);
        do_start();
        drive(0, -1);
        repeat (2) @(negedge clk);
        checks++;
        if (mem_a[200:192] !== b3[8:0]) begin
            errors++;
            $display("FAIL trunc_top: mem[200:192]=%h, required %h", mem_a[200:192], b3[8:0]);
        end
        checks++;
        if (mem_a !== exp_q[0] || qa.size() != 1) begin
            errors++;
            $display("FAIL trunc_word: got %h (strobes %0d), required %h (1)", mem_a, qa.size(), exp_q[0]);
        end
        $display("truncation: top=%h", mem_a[200:192]);
    endtask

    task automatic test_reset_mid();
        fill_random(8, 7);
        build_expected(1024);
        exp_n = 6;
        do_start();
        drive(0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy_a, en_a, busy_a, done_a, err_a} !== 5'b0 || mem_a !== '0 || words_a !== '0) begin
            errors++;
            $display("FAIL midreset: rdy/en/busy/done/err=%b mem=%h words=%0d, required all 0",
                     {rdy_a, en_a, busy_a, done_a, err_a}, mem_a, words_a);
        end
        rst_n = 1'b1;
        fill_random(4, 3);
        build_expected(1024);
        do_start();
        drive(1, -1);
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 1 || words_a !== 11'd1 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL restart_status: strobes=%0d words=%0d done=%b, required 1 1 1",
                     qa.size(), words_a, done_a);
        end
        checks++;
        if (qa.size() < 1 || qa[0].d !== exp_q[0]) begin
            errors++;
            $display("FAIL restart_word: got %h, required %h", (qa.size() > 0) ? qa[0].d : 'x, exp_q[0]);
        end
        $display("reset_mid: strobes=%0d words=%0d", qa.size(), words_a);
    endtask

    task automatic test_random();
        int nb;
        int li;
        for (int it = 0; it < 8; it++) begin
            nb = 4 * $urandom_range(4, 1);
            li = ($urandom_range(9, 0) < 7) ? nb - 1 : $urandom_range(nb - 1, 0);
            fill_random(nb, li);
            build_expected(1024);
            do_start();
            drive(3, -1);
            repeat (2) @(negedge clk);
            checks++;
            if (qa.size() != exp_q.size() || words_a !== 11'(exp_cnt) ||
                done_a !== exp_done || err_a !== exp_err) begin
                errors++;
                $display("FAIL rand%0d_status: strobes=%0d words=%0d done=%b err=%b, required %0d %0d %b %b",
                         it, qa.size(), words_a, done_a, err_a, exp_q.size(), exp_cnt, exp_done, exp_err);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (i >= qa.size() || qa[i].d !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got %h, required %h", it, i,
                             (i < qa.size()) ? qa[i].d : 'x, exp_q[i]);
                end
            end
            for (int i = 1; i < qa.size(); i++) begin
                checks++;
                if (qa[i].c - qa[i-1].c < 4) begin
                    errors++;
                    $display("FAIL rand%0d_spacing: %0d cycles between strobes, required >= 4",
                             it, qa[i].c - qa[i-1].c);
                end
            end
            $display("random %0d: beats=%0d last=%0d strobes=%0d done=%b err=%b",
                     it, nb, li, qa.size(), done_a, err_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_early_last();
        test_overflow();
        test_truncation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
